// File: rtl/ex_stage_if.sv
// ex_stage_if: groups the EX stage's pipeline and data-SRAM signals.
//   stall               : 6-bit pipeline stall vector (1 = stop)
//   id_to_ex_bus        : 124-bit instruction payload from ID
//   ex_to_mem_bus       : 147-bit payload to MEM
//   ex_to_id_forwarding : 38-bit {rf_we, rf_waddr, ex_result} bypass to ID
//   data_sram_*         : en / wen[3:0] / addr[31:0] / wdata[31:0] request
//   stallreq_for_ex     : EX asks the controller to hold the pipeline
// modport master = pipeline side (ID/controller/MEM), slave = ex_stage.
interface ex_stage_if;
  localparam int unsigned ID_EX_W  = 124;
  localparam int unsigned EX_MEM_W = 147;
  localparam int unsigned FWD_W    = 38;
  localparam int unsigned XLEN     = 32;

  logic [5:0]          stall;
  logic [ID_EX_W-1:0]  id_to_ex_bus;
  logic [EX_MEM_W-1:0] ex_to_mem_bus;
  logic [FWD_W-1:0]    ex_to_id_forwarding;
  logic                data_sram_en;
  logic [3:0]          data_sram_wen;
  logic [XLEN-1:0]     data_sram_addr;
  logic [XLEN-1:0]     data_sram_wdata;
  logic                stallreq_for_ex;

  modport master (
    output stall, id_to_ex_bus,
    input  ex_to_mem_bus, ex_to_id_forwarding, data_sram_en, data_sram_wen,
           data_sram_addr, data_sram_wdata, stallreq_for_ex
  );

  modport slave (
    input  stall, id_to_ex_bus,
    output ex_to_mem_bus, ex_to_id_forwarding, data_sram_en, data_sram_wen,
           data_sram_addr, data_sram_wdata, stallreq_for_ex
  );
endinterface

// File: rtl/ex_stage.sv
// ex_stage: execute stage of a 5-stage MIPS-style pipeline.
//   clk   : clock, all state on rising edge
//   rst   : synchronous active-high reset
//   ex_if : ex_stage_if.slave (stall, id_to_ex_bus in; MEM bus, forwarding,
//           data SRAM request and stallreq_for_ex out)
// Holds the ID/EX pipeline register, the ALU, load/store address and lane
// generation, and HI/LO result selection.
// Build option: define EX_DIV_EN to include the 32-cycle restoring divider
// (div/divu). Without it, divide ops produce HI/LO = 0 with no HI/LO write
// and never stall.
module ex_stage (
  input  logic      clk,
  input  logic      rst,
  ex_stage_if.slave ex_if
);
  localparam int unsigned XLEN = 32;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [3:0]      alu_op;
    logic [XLEN-1:0] src1;
    logic [XLEN-1:0] src2;
    logic            rf_we;
    logic [4:0]      rf_waddr;
    logic            sel_rf_res;
    logic [4:0]      op_mem;     // lw, lb, lbu, lh, lhu
    logic [2:0]      op_st;      // sw, sh, sb
    logic [1:0]      div_op;     // div, divu
    logic            hi_we;
    logic            lo_we;
    logic [4:0]      rsv;
  } id_ex_t;

  typedef struct packed {
    logic [4:0]      op_mem;
    logic            hi_we;
    logic            lo_we;
    logic [XLEN-1:0] hi_result;
    logic [XLEN-1:0] lo_result;
    logic [XLEN-1:0] pc;
    logic            data_ram_en;
    logic [3:0]      data_ram_wen;
    logic            sel_rf_res;
    logic            rf_we;
    logic [4:0]      rf_waddr;
    logic [XLEN-1:0] ex_result;
  } ex_mem_t;

  id_ex_t ex_q;

  // ID/EX register: load, insert bubble, or hold
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q <= '0;
    end else if (!ex_if.stall[2]) begin
      ex_q <= ex_if.id_to_ex_bus;
    end else if (!ex_if.stall[3]) begin
      ex_q <= '0;
    end
  end

  // ALU
  logic [XLEN-1:0] alu_res;
  always_comb begin
    alu_res = '0;
    case (ex_q.alu_op)
      4'd0:    alu_res = ex_q.src1 + ex_q.src2;
      4'd1:    alu_res = ex_q.src1 - ex_q.src2;
      4'd2:    alu_res = XLEN'($signed(ex_q.src1) < $signed(ex_q.src2));
      4'd3:    alu_res = XLEN'(ex_q.src1 < ex_q.src2);
      4'd4:    alu_res = ex_q.src1 & ex_q.src2;
      4'd5:    alu_res = ex_q.src1 | ex_q.src2;
      4'd6:    alu_res = ex_q.src1 ^ ex_q.src2;
      4'd7:    alu_res = ~(ex_q.src1 | ex_q.src2);
      4'd8:    alu_res = ex_q.src2 << ex_q.src1[4:0];
      4'd9:    alu_res = ex_q.src2 >> ex_q.src1[4:0];
      4'd10:   alu_res = XLEN'($signed(ex_q.src2) >>> ex_q.src1[4:0]);
      4'd11:   alu_res = {ex_q.src2[15:0], 16'h0000};
      4'd12:   alu_res = ex_q.src1;
      default: alu_res = '0;
    endcase
  end

  // Load/store address and store byte lanes; store data operand is src2
  logic            is_mem;
  logic [XLEN-1:0] mem_addr;
  logic [3:0]      st_wen;
  logic [XLEN-1:0] st_wdata;

  assign is_mem   = (|ex_q.op_mem) | (|ex_q.op_st);
  assign mem_addr = ex_q.src1 + ex_q.src2;

  always_comb begin
    st_wen   = 4'b0000;
    st_wdata = '0;
    if (ex_q.op_st[2]) begin
      st_wen   = 4'b1111;
      st_wdata = ex_q.src2;
    end else if (ex_q.op_st[1]) begin
      st_wen   = mem_addr[1] ? 4'b1100 : 4'b0011;
      st_wdata = {2{ex_q.src2[15:0]}};
    end else if (ex_q.op_st[0]) begin
      st_wen   = 4'(4'b0001 << mem_addr[1:0]);
      st_wdata = {4{ex_q.src2[7:0]}};
    end
  end

  logic            is_div;
  logic            div_busy;
  logic            div_res_vld;
  logic [XLEN-1:0] div_hi;
  logic [XLEN-1:0] div_lo;

  assign is_div = |ex_q.div_op;

`ifdef EX_DIV_EN
  localparam int unsigned CNT_W = 5;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_CALC = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;

  div_state_e      state_q, state_d;
  logic            load_calc, load_zero, step, last_step;
  logic [CNT_W-1:0] cnt_q;
  logic [XLEN-1:0] quo_q, rem_q, dvs_q;
  logic            neg_quo_q, neg_rem_q;
  logic            div_sgn;
  logic [XLEN-1:0] dvd_mag, dvs_mag;
  logic [XLEN:0]   rem_sh, rem_diff;
  logic            fits;
  logic [XLEN-1:0] rem_nx, quo_nx;

  assign div_sgn = ex_q.div_op[1];
  assign dvd_mag = (div_sgn && ex_q.src1[XLEN-1]) ? -ex_q.src1 : ex_q.src1;
  assign dvs_mag = (div_sgn && ex_q.src2[XLEN-1]) ? -ex_q.src2 : ex_q.src2;

  // One restoring step: shift in next dividend bit, subtract if it fits
  assign rem_sh   = {rem_q, quo_q[XLEN-1]};
  assign rem_diff = rem_sh - {1'b0, dvs_q};
  assign fits     = ~rem_diff[XLEN];
  assign rem_nx   = fits ? rem_diff[XLEN-1:0] : rem_sh[XLEN-1:0];
  assign quo_nx   = {quo_q[XLEN-2:0], fits};
  assign last_step = step && (cnt_q == CNT_W'(XLEN - 1));

  // Divider state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= DIV_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Divider next state and control
  always_comb begin
    state_d     = state_q;
    load_calc   = 1'b0;
    load_zero   = 1'b0;
    step        = 1'b0;
    div_busy    = 1'b0;
    div_res_vld = 1'b0;
    case (state_q)
      DIV_IDLE: begin
        if (is_div) begin
          div_busy = 1'b1;
          if (ex_q.src2 == '0) begin
            load_zero = 1'b1;
            state_d   = DIV_DONE;
          end else begin
            load_calc = 1'b1;
            state_d   = DIV_CALC;
          end
        end
      end
      DIV_CALC: begin
        div_busy = 1'b1;
        step     = 1'b1;
        if (cnt_q == CNT_W'(XLEN - 1)) begin
          state_d = DIV_DONE;
        end
      end
      DIV_DONE: begin
        div_res_vld = 1'b1;
        state_d     = DIV_IDLE;
      end
      default: state_d = DIV_IDLE;
    endcase
  end

  // Divider datapath; signs are applied on the final step so DONE reads
  // finished results straight from quo_q/rem_q
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      quo_q     <= '0;
      rem_q     <= '0;
      dvs_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
    end else if (load_calc) begin
      cnt_q     <= '0;
      quo_q     <= dvd_mag;
      rem_q     <= '0;
      dvs_q     <= dvs_mag;
      neg_quo_q <= div_sgn & (ex_q.src1[XLEN-1] ^ ex_q.src2[XLEN-1]);
      neg_rem_q <= div_sgn & ex_q.src1[XLEN-1];
    end else if (load_zero) begin
      cnt_q     <= '0;
      quo_q     <= '1;
      rem_q     <= ex_q.src1;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
    end else if (step) begin
      cnt_q <= cnt_q + CNT_W'(1);
      if (last_step) begin
        quo_q <= neg_quo_q ? -quo_nx : quo_nx;
        rem_q <= neg_rem_q ? -rem_nx : rem_nx;
      end else begin
        quo_q <= quo_nx;
        rem_q <= rem_nx;
      end
    end
  end

  assign div_hi = div_res_vld ? rem_q : '0;
  assign div_lo = div_res_vld ? quo_q : '0;
`else
  assign div_busy    = 1'b0;
  assign div_res_vld = 1'b0;
  assign div_hi      = '0;
  assign div_lo      = '0;
`endif

  // EX/MEM payload; divide HI/LO writes only on the result cycle
  ex_mem_t mem_o;
  always_comb begin
    mem_o              = '0;
    mem_o.op_mem       = ex_q.op_mem;
    mem_o.hi_we        = ex_q.hi_we & (~is_div | div_res_vld);
    mem_o.lo_we        = ex_q.lo_we & (~is_div | div_res_vld);
    mem_o.hi_result    = is_div ? div_hi : ex_q.src1;
    mem_o.lo_result    = is_div ? div_lo : ex_q.src1;
    mem_o.pc           = ex_q.pc;
    mem_o.data_ram_en  = is_mem;
    mem_o.data_ram_wen = st_wen;
    mem_o.sel_rf_res   = ex_q.sel_rf_res;
    mem_o.rf_we        = ex_q.rf_we;
    mem_o.rf_waddr     = ex_q.rf_waddr;
    mem_o.ex_result    = is_mem ? mem_addr : alu_res;
  end

  assign ex_if.ex_to_mem_bus       = mem_o;
  assign ex_if.ex_to_id_forwarding = {mem_o.rf_we, mem_o.rf_waddr, mem_o.ex_result};
  assign ex_if.data_sram_en        = is_mem;
  assign ex_if.data_sram_wen       = st_wen;
  assign ex_if.data_sram_addr      = mem_addr;
  assign ex_if.data_sram_wdata     = st_wdata;
  assign ex_if.stallreq_for_ex     = div_busy;

  // Stall bits for other stages and reserved payload bits are not used here
  logic unused_ok;
  assign unused_ok = ^{ex_if.stall[5:4], ex_if.stall[1:0], ex_q.rsv};
endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: randomized self-checking bench for ex_stage against a
// behavioural model built from plain integer arithmetic.
module tb_ex_stage;
`ifdef EX_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  typedef struct packed {
    logic [31:0] pc;
    logic [3:0]  alu_op;
    logic [31:0] src1;
    logic [31:0] src2;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic        sel_rf_res;
    logic [4:0]  op_mem;
    logic [2:0]  op_st;
    logic [1:0]  div_op;
    logic        hi_we;
    logic        lo_we;
    logic [4:0]  rsv;
  } id_ex_t;

  typedef struct packed {
    logic [4:0]  op_mem;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] hi_result;
    logic [31:0] lo_result;
    logic [31:0] pc;
    logic        data_ram_en;
    logic [3:0]  data_ram_wen;
    logic        sel_rf_res;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] ex_result;
  } ex_mem_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ex_stage_if eif ();
  ex_stage dut (.clk(clk), .rst(rst), .ex_if(eif));

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string tag, input logic [146:0] got, input logic [146:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] exp_wen(input id_ex_t i);
    logic [31:0] addr;
    addr = i.src1 + i.src2;
    if (i.op_st == 3'b100) return 4'hF;
    if (i.op_st == 3'b010) return ((addr % 4) >= 2) ? 4'hC : 4'h3;
    if (i.op_st == 3'b001) return 4'(1 << (addr % 4));
    return 4'h0;
  endfunction

  function automatic logic [31:0] exp_wdata(input id_ex_t i);
    if (i.op_st == 3'b100) return i.src2;
    if (i.op_st == 3'b010) return (i.src2 % 65536) * 32'h0001_0001;
    if (i.op_st == 3'b001) return (i.src2 % 256) * 32'h0101_0101;
    return 32'h0;
  endfunction

  function automatic int exp_stall(input id_ex_t i);
    if (!DIV_EN || i.div_op == 2'b00) return 0;
    return (i.src2 == 32'h0) ? 1 : 33;
  endfunction

  // Expected MEM payload at the cycle the instruction's result is visible
  function automatic ex_mem_t model(input id_ex_t i);
    ex_mem_t     o;
    logic [31:0] a, b, addr, res;
    longint      sa, sb, q, r;
    bit          mem;
    o = '0;
    a = i.src1;
    b = i.src2;
    addr = a + b;
    case (i.alu_op)
      4'd0:    res = a + b;
      4'd1:    res = a - b;
      4'd2:    res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd3:    res = (a < b) ? 32'd1 : 32'd0;
      4'd4:    res = a & b;
      4'd5:    res = a | b;
      4'd6:    res = a ^ b;
      4'd7:    res = ~(a | b);
      4'd8:    res = b << a[4:0];
      4'd9:    res = b >> a[4:0];
      4'd10:   res = 32'($signed(b) >>> a[4:0]);
      4'd11:   res = b * 32'd65536;
      4'd12:   res = a;
      default: res = 32'h0;
    endcase
    mem = (i.op_mem != 5'b0) || (i.op_st != 3'b0);
    o.op_mem       = i.op_mem;
    o.pc           = i.pc;
    o.sel_rf_res   = i.sel_rf_res;
    o.rf_we        = i.rf_we;
    o.rf_waddr     = i.rf_waddr;
    o.data_ram_en  = mem;
    o.data_ram_wen = exp_wen(i);
    o.ex_result    = mem ? addr : res;
    if (i.div_op != 2'b00) begin
      if (DIV_EN) begin
        if (b == 32'h0) begin
          q = 64'h0000_0000_FFFF_FFFF;
          r = longint'({32'h0, a});
        end else if (i.div_op == 2'b10) begin
          sa = longint'($signed(a));
          sb = longint'($signed(b));
          q = sa / sb;
          r = sa % sb;
        end else begin
          sa = longint'({32'h0, a});
          sb = longint'({32'h0, b});
          q = sa / sb;
          r = sa % sb;
        end
        o.hi_result = r[31:0];
        o.lo_result = q[31:0];
        o.hi_we     = i.hi_we;
        o.lo_we     = i.lo_we;
      end
    end else begin
      o.hi_result = a;
      o.lo_result = a;
      o.hi_we     = i.hi_we;
      o.lo_we     = i.lo_we;
    end
    return o;
  endfunction

  function automatic id_ex_t rand_base();
    id_ex_t i;
    i = '0;
    i.pc         = $urandom;
    i.rf_we      = 1'($urandom);
    i.rf_waddr   = 5'($urandom);
    i.sel_rf_res = 1'($urandom);
    i.rsv        = 5'($urandom);
    i.src1       = $urandom;
    i.src2       = $urandom;
    return i;
  endfunction

  function automatic id_ex_t mk_div(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    id_ex_t i;
    i = rand_base();
    i.alu_op = 4'd12;
    i.div_op = op;
    i.src1   = a;
    i.src2   = b;
    i.hi_we  = 1'b1;
    i.lo_we  = 1'b1;
    return i;
  endfunction

  task automatic check_outputs(input string tag, input id_ex_t i);
    ex_mem_t e;
    e = model(i);
    check({tag, ".bus"}, eif.ex_to_mem_bus, e);
    check({tag, ".fwd"}, 147'(eif.ex_to_id_forwarding), 147'({e.rf_we, e.rf_waddr, e.ex_result}));
    check({tag, ".sram"},
          147'({eif.data_sram_en, eif.data_sram_wen, eif.data_sram_addr, eif.data_sram_wdata}),
          147'({e.data_ram_en, e.data_ram_wen, i.src1 + i.src2, exp_wdata(i)}));
  endtask

  // Issue one instruction, follow the stall handshake, check its result
  task automatic run_instr(input string tag, input id_ex_t i);
    int n;
    eif.id_to_ex_bus = i;
    eif.stall = 6'b000000;
    @(posedge clk); #1;
    n = 0;
    while (eif.stallreq_for_ex === 1'b1 && n < 100) begin
      eif.stall = 6'b001111;
      @(posedge clk); #1;
      n++;
    end
    eif.stall = 6'b000000;
    check({tag, ".stall_cycles"}, 147'(n), 147'(exp_stall(i)));
    check_outputs(tag, i);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    id_ex_t  i, a_ins, b_ins;
    ex_mem_t e;
    int      cat;

    // Reset clears everything
    rst = 1'b1;
    eif.stall = 6'b000000;
    eif.id_to_ex_bus = rand_base();
    repeat (2) @(posedge clk);
    #1;
    check("reset.bus", eif.ex_to_mem_bus, 147'(0));
    check("reset.fwd", 147'(eif.ex_to_id_forwarding), 147'(0));
    check("reset.sram", 147'({eif.data_sram_en, eif.data_sram_wen, eif.data_sram_addr, eif.data_sram_wdata}), 147'(0));
    check("reset.stallreq", 147'(eif.stallreq_for_ex), 147'(0));
    rst = 1'b0;

    // add wraps without trapping
    i = rand_base();
    i.alu_op = 4'd0; i.src1 = 32'h7FFF_FFFF; i.src2 = 32'h0000_0001;
    run_instr("add_wrap", i);
    check("add_wrap.result", 147'(eif.ex_to_id_forwarding[31:0]), 147'(32'h8000_0000));

    // sb to byte 3
    i = rand_base();
    i.alu_op = 4'd0; i.op_st = 3'b001; i.src1 = 32'h0000_0F58; i.src2 = 32'h0000_00AB;
    run_instr("sb", i);
    check("sb.lanes", 147'({eif.data_sram_en, eif.data_sram_wen, eif.data_sram_wdata}),
          147'({1'b1, 4'b1000, 32'hABAB_ABAB}));

    i = rand_base(); i.op_st = 3'b010; i.src1 = 32'h2000; i.src2 = 32'h0000_1236;
    run_instr("sh_hi", i);
    i = rand_base(); i.op_st = 3'b100;
    run_instr("sw", i);
    i = rand_base(); i.op_mem = 5'b10000;
    run_instr("lw", i);

    // Every ALU opcode, including undefined ones
    for (int op = 0; op < 16; op++) begin
      i = rand_base();
      i.alu_op = 4'(op);
      if (op >= 8 && op <= 10) i.src1 = 32'($urandom_range(0, 63));
      run_instr($sformatf("alu%0d", op), i);
    end

    i = rand_base(); i.alu_op = 4'd12; i.hi_we = 1'b1;
    run_instr("mthi", i);

    // Divider cases
    i = mk_div(2'b01, 32'd100, 32'd7);
    run_instr("divu_100_7", i);
    check("divu_100_7.lo_hi", 147'({eif.ex_to_mem_bus[107:76], eif.ex_to_mem_bus[139:108]}),
          DIV_EN ? 147'({32'd14, 32'd2}) : 147'(0));
    run_instr("div_m7_2", mk_div(2'b10, 32'hFFFF_FFF9, 32'd2));
    run_instr("div_by0", mk_div(2'b10, 32'h1234_5678, 32'd0));
    run_instr("divu_by0", mk_div(2'b01, 32'hDEAD_BEEF, 32'd0));
    run_instr("div_ovf", mk_div(2'b10, 32'h8000_0000, 32'hFFFF_FFFF));
    run_instr("div_negdvs", mk_div(2'b10, 32'd1000, 32'hFFFF_FFF5));
    run_instr("b2b_1", mk_div(2'b01, 32'hFFFF_FFFF, 32'd10));
    run_instr("b2b_2", mk_div(2'b01, 32'd55, 32'd11));

    // Reset in the middle of a division
    i = mk_div(2'b01, 32'hFFFF_FFFF, 32'd3);
    eif.id_to_ex_bus = i;
    eif.stall = 6'b000000;
    @(posedge clk); #1;
    for (int k = 0; k < 10; k++) begin
      eif.stall = {2'b00, {4{eif.stallreq_for_ex}}};
      @(posedge clk); #1;
    end
    rst = 1'b1;
    eif.stall = 6'b000000;
    @(posedge clk); #1;
    check("midreset.stallreq", 147'(eif.stallreq_for_ex), 147'(0));
    check("midreset.bus", eif.ex_to_mem_bus, 147'(0));
    rst = 1'b0;
    run_instr("divu_9_3", mk_div(2'b01, 32'd9, 32'd3));

    // Bubble insertion and hold
    a_ins = rand_base(); a_ins.alu_op = 4'd0;
    b_ins = rand_base(); b_ins.alu_op = 4'd5;
    run_instr("bubble_pre", a_ins);
    eif.id_to_ex_bus = b_ins;
    eif.stall = 6'b000100;
    @(posedge clk); #1;
    check("bubble.bus", eif.ex_to_mem_bus, 147'(0));
    check("bubble.fwd", 147'(eif.ex_to_id_forwarding), 147'(0));
    run_instr("hold_pre", a_ins);
    eif.id_to_ex_bus = b_ins;
    eif.stall = 6'b001100;
    repeat (2) @(posedge clk);
    #1;
    e = model(a_ins);
    check("hold.bus", eif.ex_to_mem_bus, e);
    eif.stall = 6'b000000;

    // Random instruction mix
    for (int n = 0; n < 80; n++) begin
      cat = int'($urandom_range(0, 4));
      i = rand_base();
      i.alu_op = 4'($urandom);
      i.hi_we  = 1'($urandom);
      i.lo_we  = 1'($urandom);
      case (cat)
        1: i.op_mem = 5'(1 << $urandom_range(0, 4));
        2: i.op_st  = 3'(1 << $urandom_range(0, 2));
        3: i.alu_op = 4'd12;
        4: begin
          i.div_op = $urandom_range(0, 1) != 0 ? 2'b10 : 2'b01;
          case ($urandom_range(0, 3))
            0: i.src2 = 32'h0;
            1: i.src2 = 32'hFFFF_FFFF;
            2: i.src2 = 32'($urandom_range(1, 20));
            default: i.src2 = $urandom;
          endcase
          if ($urandom_range(0, 5) == 0) i.src1 = 32'h8000_0000;
        end
        default: ;
      endcase
      run_instr($sformatf("rand%0d", n), i);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
